// File: rtl/q_solver.sv
// q_solver: recovers operand a from a logged Q result, where
//   Q = ((a - b) * (1 + 3c) - 4d) >>> 1, so a = b + (2Q + 4d) / (1 + 3c).
// One signed restoring division, one quotient bit per clock, valid/ready on
// both sides. Optional build macro: Q_SOLVER_ODD_RETRY_EN enables a second
// division with numerator 2Q + 4d + 1. That numerator restores the LSB that
// the calculator's arithmetic shift may have dropped.
module q_solver #(
  parameter  int WIDTH = 16,
  localparam int EXT   = 2 * WIDTH
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    valid_in,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] Q,
  input  logic signed [WIDTH-1:0] b,
  input  logic signed [WIDTH-1:0] c,
  input  logic signed [WIDTH-1:0] d,
  output logic                    valid_out,
  input  logic                    out_ready,
  output logic signed [WIDTH-1:0] a,
  output logic signed [EXT-1:0]   rem,
  output logic                    exact,
  output logic                    retried,
  output logic                    ovf
);

  localparam int CNT_W = $clog2(EXT);

  typedef enum logic [2:0] {IDLE, PREP, DIV, FIX, DONE} state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0] qOp_q, bOp_q, cOp_q, dOp_q;
  logic [EXT-1:0]   numSh_q, denMag_q, remAcc_q, quot_q;
  logic [CNT_W-1:0] cnt_q;
  logic             negN_q, negD_q;

  logic [WIDTH-1:0] aOut_q;
  logic [EXT-1:0]   remOut_q;
  logic             exact_q, retried_q, ovf_q;

  logic [EXT-1:0] qExt, bExt, cExt, dExt;
  logic [EXT-1:0] numFull, denFull, numMag, denMag;
  logic [EXT-1:0] remShift, quotS, remS, selQuot, selRem, sumFull;
  logic [EXT:0]   trial;
  logic           bitOk, negQ, ovfCalc;
  logic           secondAttempt, needRetry;

  assign qExt = {{(EXT-WIDTH){qOp_q[WIDTH-1]}}, qOp_q};
  assign bExt = {{(EXT-WIDTH){bOp_q[WIDTH-1]}}, bOp_q};
  assign cExt = {{(EXT-WIDTH){cOp_q[WIDTH-1]}}, cOp_q};
  assign dExt = {{(EXT-WIDTH){dOp_q[WIDTH-1]}}, dOp_q};

  assign numFull = (qExt << 1) + (dExt << 2) + {{(EXT-1){1'b0}}, secondAttempt};
  assign denFull = (cExt << 1) + cExt + {{(EXT-1){1'b0}}, 1'b1};
  assign numMag  = numFull[EXT-1] ? (~numFull + 1'b1) : numFull;
  assign denMag  = denFull[EXT-1] ? (~denFull + 1'b1) : denFull;

  assign remShift = {remAcc_q[EXT-2:0], numSh_q[EXT-1]};
  assign trial    = {1'b0, remShift} - {1'b0, denMag_q};
  assign bitOk    = ~trial[EXT];

  assign negQ  = negN_q ^ negD_q;
  assign quotS = negQ   ? (~quot_q + 1'b1)   : quot_q;
  assign remS  = negN_q ? (~remAcc_q + 1'b1) : remAcc_q;

`ifdef Q_SOLVER_ODD_RETRY_EN
  logic           attempt2_q;
  logic [EXT-1:0] savedQuot_q, savedRem_q;
  logic           useSaved;

  assign secondAttempt = attempt2_q;
  assign needRetry     = ~attempt2_q && (remS != '0);
  assign useSaved      = attempt2_q && (remS != '0);
  assign selQuot       = useSaved ? savedQuot_q : quotS;
  assign selRem        = useSaved ? savedRem_q  : remS;

  // Remember the first inexact attempt so it can be reported if the retry is also inexact
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      attempt2_q  <= 1'b0;
      savedQuot_q <= '0;
      savedRem_q  <= '0;
    end else if (state_q == IDLE && valid_in) begin
      attempt2_q  <= 1'b0;
    end else if (state_q == FIX && needRetry) begin
      attempt2_q  <= 1'b1;
      savedQuot_q <= quotS;
      savedRem_q  <= remS;
    end
  end
`else
  assign secondAttempt = 1'b0;
  assign needRetry     = 1'b0;
  assign selQuot       = quotS;
  assign selRem        = remS;
`endif

  assign sumFull = bExt + selQuot;
  assign ovfCalc = (sumFull[EXT-1:WIDTH-1] != '0) && (sumFull[EXT-1:WIDTH-1] != '1);

  // State register; reset abandons any division in flight
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state sequencing and handshake outputs
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    valid_out = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (valid_in) state_d = PREP;
      end
      PREP:    state_d = DIV;
      DIV:     if (cnt_q == '0) state_d = FIX;
      FIX:     state_d = needRetry ? PREP : DONE;
      DONE: begin
        valid_out = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Operand capture, restoring division steps and result registration
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      qOp_q     <= '0;
      bOp_q     <= '0;
      cOp_q     <= '0;
      dOp_q     <= '0;
      numSh_q   <= '0;
      denMag_q  <= '0;
      remAcc_q  <= '0;
      quot_q    <= '0;
      cnt_q     <= '0;
      negN_q    <= 1'b0;
      negD_q    <= 1'b0;
      aOut_q    <= '0;
      remOut_q  <= '0;
      exact_q   <= 1'b0;
      retried_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (valid_in) begin
            qOp_q <= Q;
            bOp_q <= b;
            cOp_q <= c;
            dOp_q <= d;
          end
        end
        PREP: begin
          numSh_q  <= numMag;
          denMag_q <= denMag;
          negN_q   <= numFull[EXT-1];
          negD_q   <= denFull[EXT-1];
          remAcc_q <= '0;
          quot_q   <= '0;
          cnt_q    <= CNT_W'(EXT - 1);
        end
        DIV: begin
          remAcc_q <= bitOk ? trial[EXT-1:0] : remShift;
          quot_q   <= {quot_q[EXT-2:0], bitOk};
          numSh_q  <= {numSh_q[EXT-2:0], 1'b0};
          cnt_q    <= cnt_q - CNT_W'(1);
        end
        FIX: begin
          if (!needRetry) begin
            aOut_q    <= sumFull[WIDTH-1:0];
            remOut_q  <= selRem;
            exact_q   <= (selRem == '0);
            retried_q <= secondAttempt;
            ovf_q     <= ovfCalc;
          end
        end
        default: ;
      endcase
    end
  end

  assign a       = aOut_q;
  assign rem     = remOut_q;
  assign exact   = exact_q;
  assign retried = retried_q;
  assign ovf     = ovf_q;

endmodule

// File: tb/tb_q_solver.sv
// tb_q_solver: directed vectors with hand-computed results for q_solver.
// Expectations follow whether Q_SOLVER_ODD_RETRY_EN is defined for the build.
module tb_q_solver;

  localparam int WIDTH = 16;
  localparam int EXT   = 2 * WIDTH;
`ifdef Q_SOLVER_ODD_RETRY_EN
  localparam bit RETRY = 1'b1;
`else
  localparam bit RETRY = 1'b0;
`endif

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic                    valid_in = 1'b0;
  logic                    in_ready;
  logic signed [WIDTH-1:0] Q = '0, b = '0, c = '0, d = '0;
  logic                    valid_out;
  logic                    out_ready = 1'b1;
  logic signed [WIDTH-1:0] a;
  logic signed [EXT-1:0]   rem;
  logic                    exact, retried, ovf;

  int assertCount = 0;
  int failCount   = 0;
  int latency;
  logic [WIDTH-1:0] holdA;
  logic [EXT-1:0]   holdRem;

  q_solver #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .in_ready(in_ready),
    .Q(Q), .b(b), .c(c), .d(d), .valid_out(valid_out), .out_ready(out_ready),
    .a(a), .rem(rem), .exact(exact), .retried(retried), .ovf(ovf)
  );

  // Free-running clock, period 10
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    assertCount++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait for IDLE, present one operand set, count cycles until valid_out
  task automatic applyStimulus(input logic [WIDTH-1:0] qv, bv, cv, dv);
    int guard;
    guard = 0;
    while (!in_ready && guard < 200) begin
      tick();
      guard++;
    end
    Q = qv; b = bv; c = cv; d = dv;
    valid_in = 1'b1;
    tick();
    valid_in = 1'b0;
    latency = 1;
    while (!valid_out && latency < 200) begin
      tick();
      latency++;
    end
    if (!valid_out) checkOutput("valid_out timeout", {63'b0, valid_out}, 64'd1);
  endtask

  task automatic runCase(input string tag, input logic [WIDTH-1:0] qv, bv, cv, dv,
                         input logic [WIDTH-1:0] aEn, input logic [EXT-1:0] remEn, input logic exEn,
                         input logic rtEn,
                         input logic [WIDTH-1:0] aDis, input logic [EXT-1:0] remDis, input logic exDis,
                         input logic ovfExp);
    int expLat;
    expLat = (RETRY && rtEn) ? 2 * EXT + 5 : EXT + 3;
    applyStimulus(qv, bv, cv, dv);
    checkOutput({tag, " latency"}, 64'(latency), 64'(expLat));
    checkOutput({tag, " a"},       64'($unsigned(a)),   64'(RETRY ? aEn : aDis));
    checkOutput({tag, " rem"},     64'($unsigned(rem)), 64'(RETRY ? remEn : remDis));
    checkOutput({tag, " exact"},   64'(exact),   64'(RETRY ? exEn : exDis));
    checkOutput({tag, " retried"}, 64'(retried), 64'(RETRY & rtEn));
    checkOutput({tag, " ovf"},     64'(ovf),     64'(ovfExp));
    if (out_ready) begin
      tick();
      checkOutput({tag, " valid_out drop"}, 64'(valid_out), 64'd0);
      checkOutput({tag, " in_ready back"},  64'(in_ready),  64'd1);
    end
  endtask

  // Directed sequence
  initial begin
    tick();
    tick();
    checkOutput("reset in_ready",  64'(in_ready),  64'd1);
    checkOutput("reset valid_out", 64'(valid_out), 64'd0);
    checkOutput("reset a",         64'($unsigned(a)), 64'd0);
    checkOutput("reset rem",       64'($unsigned(rem)), 64'd0);
    checkOutput("reset flags",     64'({exact, retried, ovf}), 64'd0);
    rst_n = 1'b1;
    tick();

    runCase("exact",      16'd19, 16'd4,     16'd2,      16'd1,
            16'd10, 32'd0, 1'b1, 1'b0, 16'd10, 32'd0, 1'b1, 1'b0);
    runCase("odd retry",  16'd3,  16'd0,     16'd2,      16'd0,
            16'd1,  32'd0, 1'b1, 1'b1, 16'd0,  32'd6, 1'b0, 1'b0);
    runCase("both inex",  16'd1,  16'd0,     16'd1,      16'd0,
            16'd0,  32'd2, 1'b0, 1'b1, 16'd0,  32'd2, 1'b0, 1'b0);
    runCase("neg Q",      16'hFFFA, 16'd1,   16'd1,      16'd0,
            16'hFFFE, 32'd0, 1'b1, 1'b0, 16'hFFFE, 32'd0, 1'b1, 1'b0);
    runCase("overflow",   16'd2,  16'd32767, 16'd0,      16'd0,
            16'h8003, 32'd0, 1'b1, 1'b0, 16'h8003, 32'd0, 1'b1, 1'b1);
    runCase("neg D",      16'd5,  16'd0,     16'hFFFF,   16'd0,
            16'hFFFB, 32'd0, 1'b1, 1'b0, 16'hFFFB, 32'd0, 1'b1, 1'b0);
    runCase("neg rem",    16'hFFFD, 16'd0,   16'd1,      16'd0,
            16'hFFFF, 32'hFFFFFFFE, 1'b0, 1'b1, 16'hFFFF, 32'hFFFFFFFE, 1'b0, 1'b0);

    // Back-pressure: result must hold and new operands must be ignored
    out_ready = 1'b0;
    runCase("hold",       16'd19, 16'd4,     16'd2,      16'd1,
            16'd10, 32'd0, 1'b1, 1'b0, 16'd10, 32'd0, 1'b1, 1'b0);
    holdA   = a;
    holdRem = rem;
    for (int i = 0; i < 10; i++) begin
      Q = 16'd100; b = 16'd7; c = 16'd3; d = 16'd2;
      valid_in = i[0];
      tick();
      checkOutput("hold a",         64'($unsigned(a)),   64'(holdA));
      checkOutput("hold rem",       64'($unsigned(rem)), 64'(holdRem));
      checkOutput("hold valid_out", 64'(valid_out), 64'd1);
      checkOutput("hold in_ready",  64'(in_ready),  64'd0);
    end
    valid_in  = 1'b0;
    out_ready = 1'b1;
    tick();
    checkOutput("release in_ready",  64'(in_ready),  64'd1);
    checkOutput("release valid_out", 64'(valid_out), 64'd0);
    tick();
    checkOutput("idle stays idle",   64'(in_ready),  64'd1);

    // Reset in the middle of a division
    Q = 16'd19; b = 16'd4; c = 16'd2; d = 16'd1;
    valid_in = 1'b1;
    tick();
    valid_in = 1'b0;
    for (int i = 1; i < 11; i++) tick();
    rst_n = 1'b0;
    tick();
    checkOutput("midreset in_ready",  64'(in_ready),  64'd1);
    checkOutput("midreset valid_out", 64'(valid_out), 64'd0);
    checkOutput("midreset a",         64'($unsigned(a)),   64'd0);
    checkOutput("midreset rem",       64'($unsigned(rem)), 64'd0);
    checkOutput("midreset flags",     64'({exact, retried, ovf}), 64'd0);
    rst_n = 1'b1;
    tick();
    runCase("after reset", 16'd3, 16'd0, 16'd2, 16'd0,
            16'd1, 32'd0, 1'b1, 1'b1, 16'd0, 32'd6, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
